// File: rtl/cnt_core_if.sv
// Handshake/bus bundle between the event counter core and its controller.
// The master drives run control and load data; the slave (cnt_core) returns count status.
interface cnt_core_if;
    logic       start;
    logic       stop;
    logic       up_dn;
    logic       clear;
    logic       load;
    logic [7:0] load_data;
    logic [7:0] cnt_data;
    logic       carry;
    logic       running;

    modport master (
        output start, stop, up_dn, clear, load, load_data,
        input  cnt_data, carry, running
    );

    modport slave (
        input  start, stop, up_dn, clear, load, load_data,
        output cnt_data, carry, running
    );
endinterface

// File: rtl/cnt_core.sv
// Programmable 8-bit up/down event counter with prescaler and run/stop FSM.
// Define CNT_CORE_BCD_EN to count in two packed BCD digits (00..99) instead of binary.
module cnt_core #(
    parameter int unsigned DIV     = 4,
    parameter logic [7:0]  RST_VAL = 8'h00
) (
    input logic       clk,
    input logic       rst,
    cnt_core_if.slave bus
);

    typedef enum logic {
        ST_STOPPED = 1'b0,
        ST_RUNNING = 1'b1
    } state_t;

    localparam logic [15:0] DIV_M1 = 16'(DIV - 32'd1);

`ifdef CNT_CORE_BCD_EN
    localparam logic [7:0] MAX_VAL = 8'h99;

    function automatic logic [7:0] step_up(input logic [7:0] v);
        logic [7:0] r;
        if (v[3:0] >= 4'd9) begin
            r = {v[7:4] + 4'd1, 4'd0};
        end else begin
            r = {v[7:4], v[3:0] + 4'd1};
        end
        return r;
    endfunction

    function automatic logic [7:0] step_down(input logic [7:0] v);
        logic [7:0] r;
        if (v[3:0] == 4'd0) begin
            r = {v[7:4] - 4'd1, 4'd9};
        end else begin
            r = {v[7:4], v[3:0] - 4'd1};
        end
        return r;
    endfunction

    function automatic logic [7:0] bcd_clamp(input logic [7:0] v);
        logic [3:0] hi;
        logic [3:0] lo;
        hi = (v[7:4] > 4'd9) ? 4'd9 : v[7:4];
        lo = (v[3:0] > 4'd9) ? 4'd9 : v[3:0];
        return {hi, lo};
    endfunction
`else
    localparam logic [7:0] MAX_VAL = 8'hFF;

    function automatic logic [7:0] step_up(input logic [7:0] v);
        return v + 8'd1;
    endfunction

    function automatic logic [7:0] step_down(input logic [7:0] v);
        return v - 8'd1;
    endfunction
`endif

    state_t      state_r;
    state_t      state_nxt_s;
    logic [15:0] presc_r;
    logic [15:0] presc_nxt_s;
    logic [7:0]  cnt_r;
    logic [7:0]  cnt_nxt_s;
    logic [7:0]  load_val_s;
    logic [7:0]  step_val_s;
    logic        carry_r;
    logic        carry_nxt_s;
    logic        wrap_s;
    logic        tick_s;

`ifdef CNT_CORE_BCD_EN
    assign load_val_s = bcd_clamp(bus.load_data);
`else
    assign load_val_s = bus.load_data;
`endif

    assign tick_s = (state_r == ST_RUNNING) && (presc_r == DIV_M1);

    // Run/stop next-state logic; stop dominates a simultaneous start.
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            ST_STOPPED: begin
                if (bus.start && !bus.stop) begin
                    state_nxt_s = ST_RUNNING;
                end else begin
                    state_nxt_s = ST_STOPPED;
                end
            end
            ST_RUNNING: begin
                if (bus.stop) begin
                    state_nxt_s = ST_STOPPED;
                end else begin
                    state_nxt_s = ST_RUNNING;
                end
            end
            default: state_nxt_s = ST_STOPPED;
        endcase
    end

    // Candidate count value and wrap flag for a tick in the current direction.
    always_comb begin
        step_val_s = cnt_r;
        wrap_s     = 1'b0;
        if (bus.up_dn) begin
            if (cnt_r == MAX_VAL) begin
                step_val_s = 8'h00;
                wrap_s     = 1'b1;
            end else begin
                step_val_s = step_up(cnt_r);
            end
        end else begin
            if (cnt_r == 8'h00) begin
                step_val_s = MAX_VAL;
                wrap_s     = 1'b1;
            end else begin
                step_val_s = step_down(cnt_r);
            end
        end
    end

    // Count update with priority clear > load > tick.
    always_comb begin
        cnt_nxt_s   = cnt_r;
        carry_nxt_s = 1'b0;
        if (bus.clear) begin
            cnt_nxt_s = RST_VAL;
        end else if (bus.load) begin
            cnt_nxt_s = load_val_s;
        end else if (tick_s) begin
            cnt_nxt_s   = step_val_s;
            carry_nxt_s = wrap_s;
        end else begin
            cnt_nxt_s = cnt_r;
        end
    end

    // Prescaler is zero whenever not running now or next cycle, so a stop leaves it cleared.
    always_comb begin
        presc_nxt_s = presc_r;
        if ((state_r == ST_STOPPED) || (state_nxt_s == ST_STOPPED) ||
            bus.clear || bus.load || tick_s) begin
            presc_nxt_s = 16'd0;
        end else begin
            presc_nxt_s = presc_r + 16'd1;
        end
    end

    // State, prescaler and output registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r <= ST_STOPPED;
            presc_r <= 16'd0;
            cnt_r   <= RST_VAL;
            carry_r <= 1'b0;
        end else begin
            state_r <= state_nxt_s;
            presc_r <= presc_nxt_s;
            cnt_r   <= cnt_nxt_s;
            carry_r <= carry_nxt_s;
        end
    end

    assign bus.cnt_data = cnt_r;
    assign bus.carry    = carry_r;
    assign bus.running  = (state_r == ST_RUNNING);

endmodule

// File: tb/tb_cnt_core.sv
// Self-checking bench for cnt_core (DIV=4, RST_VAL=8'h00): vector table, corner sequences,
// and random stimulus against a reference model; BCD checks when CNT_CORE_BCD_EN is defined.
module tb_cnt_core;

    localparam int DIV = 4;
    localparam logic [7:0] RST_VAL = 8'h00;

    logic clk = 1'b0;
    logic rst = 1'b0;
    int   n_checks = 0;
    int   n_fail   = 0;

    cnt_core_if bus();

    cnt_core #(.DIV(DIV), .RST_VAL(RST_VAL)) u_dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic       start;
        logic       stop;
        logic       up;
        logic       clr;
        logic       ld;
        logic [7:0] ldd;
        logic [7:0] exp_cnt;
        logic       exp_carry;
        logic       exp_run;
    } vec_t;

    vec_t tbl[$];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s at %0t: got %0h expected %0h", nm, $time, act, exp);
        end
    endtask

    task automatic chk_out(input string nm, input logic [7:0] c, input logic cy, input logic r);
        chk({nm, "_cnt"}, {24'd0, bus.cnt_data}, {24'd0, c});
        chk({nm, "_carry"}, {31'd0, bus.carry}, {31'd0, cy});
        chk({nm, "_run"}, {31'd0, bus.running}, {31'd0, r});
    endtask

    // Drive one cycle of inputs at the falling edge and advance to the next falling edge.
    task automatic cyc(input logic s, input logic p, input logic u, input logic c,
                       input logic l, input logic [7:0] d);
        bus.start = s; bus.stop = p; bus.up_dn = u;
        bus.clear = c; bus.load = l; bus.load_data = d;
        @(negedge clk);
    endtask

    task automatic add(input logic s, input logic p, input logic u, input logic c,
                       input logic l, input logic [7:0] d,
                       input logic [7:0] e, input logic ec, input logic er);
        vec_t v;
        v = '{s, p, u, c, l, d, e, ec, er};
        tbl.push_back(v);
    endtask

    task automatic do_reset();
        @(negedge clk);
        #2 rst = 1'b1;
        #1 chk_out("async_rst", RST_VAL, 1'b0, 1'b0);
        @(negedge clk);
        rst = 1'b0;
    endtask

`ifdef CNT_CORE_BCD_EN
    // Start, let the prescaler run out, and stop on the tick cycle: exactly one step occurs.
    task automatic one_step(input logic u);
        cyc(1'b1, 1'b0, u, 1'b0, 1'b0, 8'h00);
        for (int i = 0; i < DIV - 1; i++) cyc(1'b0, 1'b0, u, 1'b0, 1'b0, 8'h00);
        cyc(1'b0, 1'b1, u, 1'b0, 1'b0, 8'h00);
    endtask

    task automatic run_bcd();
        cyc(1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 8'h09);
        one_step(1'b1);
        chk_out("bcd_09_up", 8'h10, 1'b0, 1'b0);
        cyc(1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 8'h99);
        one_step(1'b1);
        chk_out("bcd_99_up", 8'h00, 1'b1, 1'b0);
        cyc(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 8'h00);
        chk_out("bcd_carry_drop", 8'h00, 1'b0, 1'b0);
        cyc(1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 8'h3C);
        chk_out("bcd_clamp", 8'h39, 1'b0, 1'b0);
        cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 8'h10);
        one_step(1'b0);
        chk_out("bcd_10_dn", 8'h09, 1'b0, 1'b0);
        cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 8'h00);
        one_step(1'b0);
        chk_out("bcd_00_dn", 8'h99, 1'b1, 1'b0);
    endtask
`else
    int m_cnt;
    int m_phase;
    bit m_run;
    bit m_carry;

    // Reference: count modulo 256, one step every DIV running cycles, clear > load > step.
    task automatic model_step(input bit s, input bit p, input bit u, input bit c,
                              input bit l, input logic [7:0] d);
        bit tk;
        bit was_run;
        int n;
        tk      = m_run && (m_phase == DIV - 1);
        was_run = m_run;
        m_carry = 1'b0;
        if (c) begin
            m_cnt = int'(RST_VAL); m_phase = 0;
        end else if (l) begin
            m_cnt = int'(d); m_phase = 0;
        end else if (tk) begin
            n       = u ? m_cnt + 1 : m_cnt - 1;
            m_carry = (n < 0) || (n > 255);
            m_cnt   = (n + 256) % 256;
            m_phase = 0;
        end else begin
            m_phase = m_phase + 1;
        end
        if (p) m_run = 1'b0;
        else if (s) m_run = 1'b1;
        if (!was_run || !m_run) m_phase = 0;
    endtask

    task automatic run_table();
        vec_t v;
        add(0,0,1,0,1,8'hFE, 8'hFE,0,0);
        add(1,0,1,0,0,8'h00, 8'hFE,0,1);
        for (int i = 0; i < 3; i++) add(0,0,1,0,0,8'h00, 8'hFE,0,1);
        for (int i = 0; i < 4; i++) add(0,0,1,0,0,8'h00, 8'hFF,0,1);
        add(0,0,1,0,0,8'h00, 8'h00,1,1);
        for (int i = 0; i < 3; i++) add(0,0,1,0,0,8'h00, 8'h00,0,1);
        add(0,0,0,0,0,8'h00, 8'hFF,1,1);
        for (int i = 0; i < 3; i++) add(0,0,0,0,0,8'h00, 8'hFF,0,1);
        add(0,0,0,1,1,8'h55, 8'h00,0,1);
        for (int i = 0; i < 3; i++) add(0,0,1,0,0,8'h00, 8'h00,0,1);
        add(0,0,1,0,1,8'h55, 8'h55,0,1);
        for (int i = 0; i < 3; i++) add(0,0,1,0,0,8'h00, 8'h55,0,1);
        add(0,0,1,0,0,8'h00, 8'h56,0,1);
        add(0,1,1,0,0,8'h00, 8'h56,0,0);
        add(0,0,1,0,0,8'h00, 8'h56,0,0);
        for (int i = 0; i < tbl.size(); i++) begin
            v = tbl[i];
            cyc(v.start, v.stop, v.up, v.clr, v.ld, v.ldd);
            chk_out($sformatf("vec%0d", i), v.exp_cnt, v.exp_carry, v.exp_run);
        end
    endtask

    task automatic run_seqs();
        // start and stop together while stopped: nothing moves
        cyc(1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 8'h00);
        chk_out("startstop0", 8'h56, 1'b0, 1'b0);
        for (int i = 0; i < 19; i++) begin
            cyc(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 8'h00);
            chk_out("startstop_hold", 8'h56, 1'b0, 1'b0);
        end
        // stop on the tick cycle: step lands, then counting halts
        cyc(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 8'h00);
        for (int i = 0; i < 3; i++) cyc(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 8'h00);
        cyc(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 8'h00);
        chk_out("stop_on_tick", 8'h57, 1'b0, 1'b0);
        for (int i = 0; i < 3; i++) begin
            cyc(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 8'h00);
            chk_out("frozen", 8'h57, 1'b0, 1'b0);
        end
        // stop mid-prescale, restart: a full DIV cycles must pass before the next step
        cyc(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 8'h00);
        cyc(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 8'h00);
        cyc(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 8'h00);
        chk_out("stop_mid", 8'h57, 1'b0, 1'b0);
        cyc(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 8'h00);
        for (int i = 0; i < 3; i++) begin
            cyc(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 8'h00);
            chk_out("restart_wait", 8'h57, 1'b0, 1'b1);
        end
        cyc(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 8'h00);
        chk_out("restart_step", 8'h58, 1'b0, 1'b1);
        // asynchronous reset between edges mid-count
        cyc(1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 8'h37);
        chk_out("load37", 8'h37, 1'b0, 1'b1);
        cyc(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 8'h00);
        do_reset();
        for (int i = 0; i < 10; i++) begin
            cyc(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 8'h00);
            chk_out("idle_after_rst", 8'h00, 1'b0, 1'b0);
        end
    endtask

    task automatic run_random();
        bit s, p, u, c, l;
        logic [7:0] d;
        logic [7:0] picks [4];
        picks[0] = 8'hFF; picks[1] = 8'h00; picks[2] = 8'hFE; picks[3] = 8'h01;
        do_reset();
        m_cnt = int'(RST_VAL); m_phase = 0; m_run = 1'b0; m_carry = 1'b0;
        for (int i = 0; i < 1500; i++) begin
            chk("rnd_cnt", {24'd0, bus.cnt_data}, 32'(m_cnt));
            chk("rnd_carry", {31'd0, bus.carry}, {31'd0, m_carry});
            chk("rnd_run", {31'd0, bus.running}, {31'd0, m_run});
            s = ($urandom_range(0, 7) == 0);
            p = ($urandom_range(0, 15) == 0);
            u = ($urandom_range(0, 1) == 1);
            c = ($urandom_range(0, 31) == 0);
            l = ($urandom_range(0, 15) == 0);
            if ($urandom_range(0, 1) == 0) d = picks[$urandom_range(0, 3)];
            else d = 8'($urandom_range(0, 255));
            model_step(s, p, u, c, l, d);
            cyc(s, p, u, c, l, d);
        end
    endtask
`endif

    initial begin
        bus.start = 1'b0; bus.stop = 1'b0; bus.up_dn = 1'b1;
        bus.clear = 1'b0; bus.load = 1'b0; bus.load_data = 8'h00;
        #1 rst = 1'b1;
        #1 chk_out("reset", RST_VAL, 1'b0, 1'b0);
        @(negedge clk);
        rst = 1'b0;
        cyc(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 8'h00);
        chk_out("post_reset", RST_VAL, 1'b0, 1'b0);
`ifdef CNT_CORE_BCD_EN
        run_bcd();
`else
        run_table();
        run_seqs();
        run_random();
`endif
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/cnt_core.md
Name: cnt_core

Overview:
- Programmable 8-bit up/down event counter with a built-in clock prescaler and run/stop control.
- Sits directly upstream of the LED display stage and drives its 8-bit count input (cnt_data).
- Provides the count value, a wrap/borrow pulse and a running status flag.

Parameters:
- DIV, 4, prescaler ratio; one count step every DIV clk cycles while running (legal range 1..65535).
- RST_VAL, 8'h00, value loaded into cnt_data on reset and on clear.

Ports:
- clk  input  1  system clock, rising-edge.
- rst  input  1  reset, asynchronous and active-high. Clears all state immediately.
- start  input  1  single-cycle pulse; requests the RUNNING state.
- stop  input  1  single-cycle pulse; requests the STOPPED state.
- up_dn  input  1  count direction: 1 = up, 0 = down. Sampled on each step.
- clear  input  1  synchronous clear of count and prescaler to RST_VAL/0.
- load  input  1  synchronous load of load_data.
- load_data  input  8  value taken on load.
- cnt_data  output  8  current count, registered, to the display stage.
- carry  output  1  one-cycle pulse on wrap (up) or borrow (down).
- running  output  1  1 while the FSM is in RUNNING.

Behaviour:
- Reset (rst=1, asynchronous): cnt_data=RST_VAL, carry=0, running=0, prescaler=0, FSM=STOPPED.
- FSM has two states, STOPPED and RUNNING; running reflects the registered state.
  - STOPPED -> RUNNING on start=1 and stop=0.
  - RUNNING -> STOPPED on stop=1.
  - start and stop together: stop wins (result is STOPPED).
  - The transition appears on running one cycle after the pulse.
- Prescaler: 16-bit counter.
  - Advances only in RUNNING; held at 0 in STOPPED.
  - tick=1 when prescaler==DIV-1 in RUNNING; prescaler then returns to 0.
  - For DIV=1, tick is asserted every RUNNING cycle.
  - The first tick after entering RUNNING arrives DIV cycles after running goes 1.
- Count update priority per cycle: clear > load > tick step.
  - clear: cnt_data=RST_VAL, prescaler=0, carry=0. FSM state is unchanged.
  - load: cnt_data=load_data, prescaler=0, carry=0. Allowed in either state.
  - tick with up_dn=1: at MAX, cnt_data=0 and carry=1; otherwise cnt_data+1.
  - tick with up_dn=0: at 0, cnt_data=MAX and carry=1; otherwise cnt_data-1.
  - MAX = 8'hFF (binary mode).
- carry is registered, is high exactly one cycle (the cycle cnt_data shows the wrapped value), and is 0 in every other cycle.
- Latency: cnt_data changes on the clk edge on which tick, clear or load is sampled.
- stop arriving in the same cycle as a tick: the step still occurs, then counting halts. The prescaler reads 0 after the stop.
- rst asserted mid-count: outputs go to reset values immediately, without waiting for clk. Counting resumes only after rst is deasserted and a new start pulse arrives.

Optional Feature:
- Macro: CNT_CORE_BCD_EN.
- Defined: cnt_data is two packed BCD digits, range 8'h00..8'h99, and MAX = 8'h99.
  - Up: low digit 9 -> 0 with carry into the high digit; 8'h99 -> 8'h00 with carry=1.
  - Down: low digit 0 -> 9 with borrow from the high digit; 8'h00 -> 8'h99 with carry=1.
  - load_data nibbles above 9 are clamped to 9 (8'h3C loads 8'h39).
  - RST_VAL must be valid BCD.
- Undefined: pure binary 0..255 as specified above; no clamping logic is generated.

Test Plan:
- Reset with DIV=4 and RST_VAL=8'h00: cnt_data=8'h00, running=0, carry=0 asynchronously. start pulse -> running=1 next cycle; cnt_data reaches 8'h01 after 4 more cycles and 8'h02 4 cycles later.
- Up wrap: load 8'hFE, start, up_dn=1 -> 8'hFF, then 8'h00 with carry=1 for exactly one cycle. Down borrow: load 8'h00, up_dn=0 -> next tick gives 8'hFF with carry=1.
- Priority: clear, load (8'h55) and tick in the same cycle -> cnt_data=RST_VAL. load and tick together -> cnt_data=8'h55, prescaler restarts, next step 4 cycles later.
- start and stop in the same cycle while STOPPED -> running stays 0 and cnt_data is unchanged over 20 cycles. stop during RUNNING -> count frozen, prescaler reads 0.
- Asynchronous reset mid-count: assert rst between clk edges at cnt_data=8'h37 -> cnt_data=8'h00 and running=0 before the next edge. Counting stays idle after release until start.
- With CNT_CORE_BCD_EN: load 8'h09, step up -> 8'h10; load 8'h99, step up -> 8'h00 with carry=1; load 8'h3C -> 8'h39; load 8'h10, step down -> 8'h09.
